// File: rtl/missile_fire_ctrl.sv
// Fire scheduler for NUM_SHOOTERS missile movers: edge-latched requests, one missile per shooter,
// per-shooter frame cooldown, global in-flight cap, round-robin single grant per frame.
// Optional in-flight timeout release is enabled with `define MISSILE_TIMEOUT_EN.
module missile_fire_ctrl #(
  parameter int NUM_SHOOTERS    = 4,
  parameter int MAX_ACTIVE      = 2,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int TIMEOUT_FRAMES  = 90
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic [NUM_SHOOTERS-1:0] fireReq,
  input  logic [NUM_SHOOTERS-1:0] missileHit,
  output logic [NUM_SHOOTERS-1:0] fireGrant,
  output logic [NUM_SHOOTERS-1:0] active,
  output logic [3:0]              activeCount,
  output logic [NUM_SHOOTERS-1:0] coolBusy
`ifdef MISSILE_TIMEOUT_EN
  ,
  output logic [NUM_SHOOTERS-1:0] timeoutKill
`endif
);

  localparam int PW = (NUM_SHOOTERS < 2) ? 1 : $clog2(NUM_SHOOTERS);
  localparam int CW = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  logic [NUM_SHOOTERS-1:0] pending;
  logic [NUM_SHOOTERS-1:0] prev_req;
  logic [NUM_SHOOTERS-1:0] rise;
  logic [NUM_SHOOTERS-1:0] elig;
  logic [NUM_SHOOTERS-1:0] win_oh;
  logic [NUM_SHOOTERS-1:0] tout;
  logic [CW-1:0]           cool [NUM_SHOOTERS];
  logic [PW-1:0]           ptr;
  logic [PW-1:0]           next_ptr;
  logic                    grant_ok;
  int                      idx;

`ifdef MISSILE_TIMEOUT_EN
  localparam int TW = (TIMEOUT_FRAMES < 1) ? 1 : $clog2(TIMEOUT_FRAMES + 1);
  logic [TW-1:0] tcnt [NUM_SHOOTERS];

  always_comb begin
    for (int i = 0; i < NUM_SHOOTERS; i++)
      tout[i] = active[i] && (tcnt[i] == TW'(TIMEOUT_FRAMES));
  end
`else
  assign tout = '0;
`endif

  assign rise = fireReq & ~prev_req;

  // NOTE: every always_comb output gets a default before any conditional code, so no latch is inferred.
  always_comb begin
    activeCount = '0;
    for (int i = 0; i < NUM_SHOOTERS; i++) begin
      activeCount = activeCount + 4'(active[i]);
      coolBusy[i] = (cool[i] != '0);
      elig[i]     = pending[i] && !active[i] && (cool[i] == '0);
    end
  end

  // Round-robin search starting at ptr; only meaningful on the startOfFrame cycle with the cap not reached.
  always_comb begin
    win_oh   = '0;
    next_ptr = ptr;
    grant_ok = 1'b0;
    idx      = 0;
    if (startOfFrame && (activeCount < 4'(MAX_ACTIVE))) begin
      for (int k = 0; k < NUM_SHOOTERS; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_SHOOTERS) idx = idx - NUM_SHOOTERS;
        if (!grant_ok && elig[idx]) begin
          grant_ok    = 1'b1;
          win_oh[idx] = 1'b1;
          next_ptr    = (idx == NUM_SHOOTERS - 1) ? '0 : PW'(idx + 1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prev_req  <= '0;
      pending   <= '0;
      active    <= '0;
      fireGrant <= '0;
      ptr       <= '0;
      // NOTE: cool is a small register array, not a RAM, so clearing it in reset is cheap and required.
      for (int i = 0; i < NUM_SHOOTERS; i++) cool[i] <= '0;
    end else begin
      prev_req  <= fireReq;
      fireGrant <= win_oh;
      ptr       <= next_ptr;
      for (int i = 0; i < NUM_SHOOTERS; i++) begin
        if (win_oh[i]) begin
          active[i]  <= 1'b1;
          pending[i] <= 1'b0;
          cool[i]    <= CW'(COOLDOWN_FRAMES);
        end else begin
          // Edges that arrive while a missile is in flight are dropped, not queued.
          if (rise[i] && !active[i]) pending[i] <= 1'b1;
          if (active[i] && (missileHit[i] || tout[i])) active[i] <= 1'b0;
          if (startOfFrame && (cool[i] != '0)) cool[i] <= cool[i] - CW'(1);
        end
      end
    end
  end

`ifdef MISSILE_TIMEOUT_EN
  // A hit on the timeout cycle wins the report, so timeoutKill only flags genuine expiries.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      timeoutKill <= '0;
      for (int i = 0; i < NUM_SHOOTERS; i++) tcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SHOOTERS; i++) begin
        timeoutKill[i] <= tout[i] && !missileHit[i];
        if (win_oh[i])
          tcnt[i] <= '0;
        else if (startOfFrame && active[i] && (tcnt[i] != TW'(TIMEOUT_FRAMES)))
          tcnt[i] <= tcnt[i] + TW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_missile_fire_ctrl.sv
// Scoreboard bench for missile_fire_ctrl: frames push expected fireGrant, a negedge monitor pops and compares.
module tb_missile_fire_ctrl;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         resetN = 1'b0;
  logic         startOfFrame = 1'b0;
  logic [N-1:0] fireReq = '0;
  logic [N-1:0] missileHit = '0;
  logic [N-1:0] fireGrant;
  logic [N-1:0] active;
  logic [3:0]   activeCount;
  logic [N-1:0] coolBusy;
`ifdef MISSILE_TIMEOUT_EN
  logic [N-1:0] timeoutKill;
`endif

  missile_fire_ctrl #(
    .NUM_SHOOTERS(N), .MAX_ACTIVE(2), .COOLDOWN_FRAMES(15), .TIMEOUT_FRAMES(90)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .fireReq(fireReq),
    .missileHit(missileHit),
    .fireGrant(fireGrant),
    .active(active),
    .activeCount(activeCount),
    .coolBusy(coolBusy)
`ifdef MISSILE_TIMEOUT_EN
    ,
    .timeoutKill(timeoutKill)
`endif
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_pass = 0;
  logic [N-1:0] exp_q[$];
  logic         last_sof = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: the cycle after every startOfFrame carries the grant decision; all other cycles must be quiet.
  always @(negedge clk) begin
    if (last_sof) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL grant_unexpected: got %b with empty scoreboard", fireGrant);
      end else begin
        check("fireGrant", 32'(fireGrant), 32'(exp_q.pop_front()));
      end
    end else if (fireGrant !== '0) begin
      n_checks++;
      $display("FAIL stray_grant: got %b expected 0 at %0t", fireGrant, $time);
    end
    last_sof = startOfFrame;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    fireReq = '0;
    missileHit = '0;
    startOfFrame = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
    tick();
  endtask

  task automatic req(input logic [N-1:0] m);
    fireReq = m;
    tick();
    fireReq = '0;
    tick();
  endtask

  task automatic hit(input logic [N-1:0] m);
    missileHit = m;
    tick();
    missileHit = '0;
    tick();
  endtask

  // Ends in the grant cycle (outputs of the grant edge visible).
  task automatic frame_raw(input logic [N-1:0] exp, input logic [N-1:0] hmask);
    startOfFrame = 1'b1;
    missileHit = hmask;
    exp_q.push_back(exp);
    tick();
    startOfFrame = 1'b0;
    missileHit = '0;
  endtask

  task automatic frame(input logic [N-1:0] exp);
    frame_raw(exp, '0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    check("reset_active", 32'(active), 0);
    check("reset_count", 32'(activeCount), 0);
    check("reset_coolBusy", 32'(coolBusy), 0);
    check("reset_grant", 32'(fireGrant), 0);

    // Single request from the player tank.
    req(4'b0001);
    frame(4'b0001);
    check("t1_active", 32'(active), 32'b0001);
    check("t1_count", 32'(activeCount), 1);
    check("t1_coolBusy", 32'(coolBusy), 32'b0001);

    // Reset mid-flight drops the missile; then all four request at once against a cap of two.
    do_reset();
    check("midflight_reset_active", 32'(active), 0);
    req(4'b1111);
    frame(4'b0001);
    frame(4'b0010);
    frame(4'b0000);
    frame(4'b0000);
    check("t2_count", 32'(activeCount), 2);
    check("t2_active", 32'(active), 32'b0011);

    // Release both; round-robin continues at shooter 2.
    hit(4'b0011);
    check("t3_released", 32'(activeCount), 0);
    frame(4'b0100);
    frame(4'b1000);
    check("t3_active", 32'(active), 32'b1100);
    hit(4'b1100);
    frame(4'b0000);

    // Cooldown: hit after two frames, re-request, grant only on the 16th frame after the original.
    do_reset();
    req(4'b0001);
    frame(4'b0001);
    frame(4'b0000);
    frame(4'b0000);
    hit(4'b0001);
    req(4'b0001);
    for (int f = 3; f <= 14; f++) frame(4'b0000);
    check("t4_cool_f14", 32'(coolBusy), 32'b0001);
    frame(4'b0000);
    check("t4_cool_f15", 32'(coolBusy), 0);
    frame(4'b0001);
    check("t4_reloaded", 32'(coolBusy), 32'b0001);

    // Hit coincident with startOfFrame while cap is full: freed slot is granted next frame.
    do_reset();
    req(4'b0011);
    frame(4'b0001);
    frame(4'b0010);
    req(4'b0100);
    frame_raw(4'b0000, 4'b0010);
    tick();
    check("t5_after_hit", 32'(active), 32'b0001);
    frame(4'b0100);
    check("t5_active", 32'(active), 32'b0101);
    hit(4'b1000);
    check("t5_idle_hit_ignored", 32'(activeCount), 2);

    // Edge while in flight is discarded: after hit, no pending request remains for shooter 2.
    req(4'b0100);
    hit(4'b0100);
    for (int f = 0; f < 16; f++) frame(4'b0000);
    check("t5_edge_discarded", 32'(active), 32'b0001);

`ifdef MISSILE_TIMEOUT_EN
    do_reset();
    req(4'b0001);
    frame(4'b0001);
    for (int f = 1; f <= 89; f++) frame(4'b0000);
    check("t6_pre_timeout_active", 32'(active), 32'b0001);
    check("t6_pre_timeout_kill", 32'(timeoutKill), 0);
    frame(4'b0000);
    check("t6_timeout_kill", 32'(timeoutKill), 32'b0001);
    check("t6_timeout_active", 32'(active), 0);
    tick();
    check("t6_kill_one_cycle", 32'(timeoutKill), 0);

    do_reset();
    req(4'b0001);
    frame(4'b0001);
    for (int f = 1; f <= 89; f++) frame(4'b0000);
    frame_raw(4'b0000, '0);
    missileHit = 4'b0001;
    tick();
    missileHit = '0;
    check("t7_hit_wins_kill", 32'(timeoutKill), 0);
    check("t7_hit_wins_active", 32'(active), 0);
`endif

    repeat (4) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
